// File: rtl/alu_cmd_issuer.sv
// Front end for the 4-bit ALU stage: accepts tagged instructions, decodes them into the
// 15-bit control word, runs one command at a time through the ALU and returns a tagged response.
module alu_cmd_issuer #(
  parameter int TAG_W       = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [14:0]      in_ctrl,
  input  logic [3:0]       in_x0,
  input  logic [3:0]       in_x1,
  input  logic [3:0]       in_y0,
  input  logic [3:0]       in_y1,
  input  logic [TAG_W-1:0] in_tag,
  output logic [3:0]       x0,
  output logic [3:0]       x1,
  output logic [3:0]       y0,
  output logic [3:0]       y1,
  output logic [14:0]      ctrl_flat,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [9:0]       res_q,
  input  logic             carry_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [9:0]       out_res,
  output logic             out_carry,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic [15:0]      cmd_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic        stale;
  logic [15:0] wdog;
  logic        timeout;

  assign timeout = (wdog == 16'(TIMEOUT_CYC - 1));

  function automatic logic [14:0] decode(input logic [3:0] op, input logic [14:0] raw);
    logic [14:0] c;
    if (op[3]) begin
      c = raw;
    end else begin
      case (op[2:0])
        3'd0:    c = 15'h4000;  // ADDX
        3'd1:    c = 15'h6000;  // SUBX
        3'd2:    c = 15'h0100;  // ADDY
        3'd3:    c = 15'h0180;  // SUBY
        3'd4:    c = 15'h1000;  // MULX
        3'd5:    c = 15'h0040;  // MULY
        3'd6:    c = 15'h4104;  // SUMXY
        default: c = 15'h4106;  // DIFFXY
      endcase
    end
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        // A stale ALU result from a timed-out command is drained before new work is taken.
        in_ready  = !stale;
        res_ready = stale;
        if (in_valid && !stale) state_nxt = ISSUE;
      end
      ISSUE: begin
        cmd_valid = 1'b1;
        if (cmd_ready) state_nxt = WAIT;
      end
      WAIT: begin
        res_ready = 1'b1;
        if (res_valid || timeout) state_nxt = RESP;
      end
      RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x0        <= '0;
      x1        <= '0;
      y0        <= '0;
      y1        <= '0;
      ctrl_flat <= '0;
      out_res   <= '0;
      out_carry <= 1'b0;
      out_tag   <= '0;
      out_err   <= 1'b0;
      cmd_count <= '0;
      stale     <= 1'b0;
      wdog      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (stale && res_valid) stale <= 1'b0;
          if (in_valid && !stale) begin
            x0        <= in_x0;
            x1        <= in_x1;
            y0        <= in_y0;
            y1        <= in_y1;
            ctrl_flat <= decode(in_op, in_ctrl);
            out_tag   <= in_tag;
          end
        end
        ISSUE: begin
          if (cmd_ready) begin
            cmd_count <= cmd_count + 16'd1;
            wdog      <= '0;
          end
        end
        WAIT: begin
          wdog <= wdog + 16'd1;
          // A result arriving on the timeout cycle takes priority over the error.
          if (res_valid) begin
            out_res   <= res_q;
            out_carry <= carry_q;
            out_err   <= 1'b0;
          end else if (timeout) begin
            out_res   <= '0;
            out_carry <= 1'b0;
            out_err   <= 1'b1;
            stale     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
